// File: rtl/filt_mem_pe_sync.sv
// Filter-memory PE: holds one filter frame (plus one prefetched), streams its taps
// MSB-first to the local MAC for NUM_PASSES passes, then optionally forwards it.
module filt_mem_pe_sync #(
  parameter  int DWIDTH     = 8,
  parameter  int KTAPS      = 3,
  parameter  int NUM_PASSES = 3,
  parameter  int FORWARD_EN = 1,
  localparam int FWIDTH     = DWIDTH*KTAPS,
  localparam int TIW        = $clog2(KTAPS),
  localparam int PIW        = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_in_valid,
  output logic              frame_in_ready,
  input  logic [FWIDTH-1:0] frame_in_data,
  output logic              tap_out_valid,
  input  logic              tap_out_ready,
  output logic [DWIDTH-1:0] tap_out_data,
  output logic [TIW-1:0]    tap_out_idx,
  output logic [PIW-1:0]    tap_out_pass,
  output logic              tap_out_last,
  output logic              frame_out_valid,
  input  logic              frame_out_ready,
  output logic [FWIDTH-1:0] frame_out_data
);

  typedef enum logic [1:0] {IDLE, STREAM, FORWARD} state_t;

  localparam bit            FWD      = (FORWARD_EN != 0);
  localparam logic [TIW-1:0] TAP_TOP = TIW'(KTAPS-1);
  localparam logic [PIW-1:0] PASS_TOP = PIW'(NUM_PASSES-1);

  state_t state, state_nxt;

  logic [KTAPS-1:0][DWIDTH-1:0] act_reg, pend_reg;
  logic                         act_full, pend_full;
  logic [TIW-1:0]               tap_idx;
  logic [PIW-1:0]               pass;

  logic in_xfer, tap_xfer, fwd_xfer, tap_last, complete;

  assign frame_in_ready = ~pend_full & ~reset;
  assign in_xfer        = frame_in_valid & frame_in_ready;
  assign tap_last       = (state == STREAM) && (tap_idx == '0) && (pass == PASS_TOP);
  assign tap_xfer       = (state == STREAM) & tap_out_ready;
  assign fwd_xfer       = (state == FORWARD) & frame_out_ready;
  // COMPLETE: frame done with this PE, either after its last tap or its forward
  assign complete       = (tap_xfer & tap_last & ~FWD) | fwd_xfer;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_xfer) state_nxt = STREAM;
      STREAM:  if (tap_xfer && tap_last) begin
                 if (FWD)                        state_nxt = FORWARD;
                 else if (pend_full || in_xfer)  state_nxt = STREAM;
                 else                            state_nxt = IDLE;
               end
      FORWARD: if (frame_out_ready)
                 state_nxt = (pend_full || in_xfer) ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tap_out_valid   = 1'b0;
    tap_out_data    = '0;
    tap_out_idx     = '0;
    tap_out_pass    = '0;
    tap_out_last    = 1'b0;
    frame_out_valid = 1'b0;
    frame_out_data  = '0;
    if (state == STREAM) begin
      tap_out_valid = act_full;
      tap_out_data  = act_reg[tap_idx];
      tap_out_idx   = tap_idx;
      tap_out_pass  = pass;
      tap_out_last  = tap_last;
    end
    if (state == FORWARD) begin
      frame_out_valid = 1'b1;
      frame_out_data  = act_reg;
    end
  end

  // A frame arriving on the COMPLETE edge bypasses the prefetch slot (which is empty then)
  always_ff @(posedge clk) begin
    if (reset) begin
      act_reg   <= '0;
      act_full  <= 1'b0;
      pend_reg  <= '0;
      pend_full <= 1'b0;
      tap_idx   <= '0;
      pass      <= '0;
    end else begin
      if (in_xfer && (state == IDLE || complete)) begin
        act_reg  <= frame_in_data;
        act_full <= 1'b1;
        tap_idx  <= TAP_TOP;
        pass     <= '0;
      end else if (complete && pend_full) begin
        act_reg   <= pend_reg;
        pend_full <= 1'b0;
        tap_idx   <= TAP_TOP;
        pass      <= '0;
      end else if (complete) begin
        act_full <= 1'b0;
      end else if (tap_xfer && !tap_last) begin
        if (tap_idx == '0) begin
          tap_idx <= TAP_TOP;
          pass    <= pass + PIW'(1);
        end else begin
          tap_idx <= tap_idx - TIW'(1);
        end
      end
      if (in_xfer && state != IDLE && !complete) begin
        pend_reg  <= frame_in_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule
